// File: rtl/fm_stream_tap_pkg.sv
// Shared types and constants for the fast-monitoring stream tap.
package fm_stream_tap_pkg;

  // Record tag width (timestamp or zero).
  localparam int FM_TAG_WIDTH = 16;

  // Widest data word a record can carry; the top slices down to DATA_WIDTH.
  localparam int FM_DATA_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } tap_state_t;

  typedef enum logic {
    FREE_RUN = 1'b0,
    WINDOW   = 1'b1
  } tap_mode_t;

  typedef struct packed {
    logic [FM_DATA_MAX_WIDTH-1:0] data;
    logic                         valid;
    logic [FM_TAG_WIDTH-1:0]      tag;
  } fm_tap_rt;

endpackage

// File: rtl/fm_tap_prescaler.sv
// Valid-word prescaler: selects one of every prescale+1 valid words.
// select is high while the count is 0; the caller qualifies it with in_valid.
module fm_tap_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk_hs,
  input  logic                      rst_hs,
  input  logic                      clear,
  input  logic                      advance,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      select
);

  localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] count;

  // Count valid words, wrapping from the latched prescale back to 0.
  always_ff @(posedge clk_hs) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst_hs || clear) begin
      count <= '0;
    end else if (advance) begin
      count <= (count == prescale) ? '0 : count + CNT_ONE;
    end
  end

  assign select = (count == '0);

endmodule

// File: rtl/fm_stream_tap.sv
// Fast-monitoring stream tap: prescaled, optionally trigger-windowed capture of
// one data stream into a registered monitor record, with a freeze request on
// window completion.
// Optional feature macro: FM_STREAM_TAP_TIMESTAMP_EN (fm_tag = 16-bit cycle
// timestamp of each forwarded word; otherwise fm_tag is 0).
module fm_stream_tap
  import fm_stream_tap_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int PRESCALE_WIDTH = 16,
  parameter int POST_WIDTH     = 10,
  parameter int TRIG_CNT_WIDTH = 8
) (
  input  logic                      clk_hs,
  input  logic                      rst_hs,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [POST_WIDTH-1:0]     post_len,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  input  logic                      trigger,
  output logic [DATA_WIDTH-1:0]     fm_data,
  output logic                      fm_valid,
  output logic [FM_TAG_WIDTH-1:0]   fm_tag,
  output logic                      freeze_req,
  output logic [TRIG_CNT_WIDTH-1:0] trig_count,
  output logic                      busy
);

  localparam logic [POST_WIDTH-1:0]     POST_ONE = POST_WIDTH'(1);
  localparam logic [TRIG_CNT_WIDTH-1:0] TRIG_ONE = TRIG_CNT_WIDTH'(1);

  tap_state_t                state, state_nxt;
  tap_mode_t                 mode_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [POST_WIDTH-1:0]     post_len_q;
  logic [POST_WIDTH-1:0]     post_cnt, post_cnt_nxt;
  logic                      cfg_load;
  logic                      active;
  logic                      sel;
  logic                      fwd;
  logic [FM_TAG_WIDTH-1:0]   tag_now;
  fm_tap_rt                  rec_q, rec_d;
  logic [TRIG_CNT_WIDTH-1:0] trig_cnt_q;

  // Words are only forwarded while armed or in the post-trigger window.
  assign active = enable && ((state == ARMED) || (state == POST));
  assign fwd    = active && in_valid && sel;

  fm_tap_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk_hs   (clk_hs),
    .rst_hs   (rst_hs),
    .clear    (!enable || (state == IDLE)),
    .advance  (active && in_valid),
    .prescale (prescale_q),
    .select   (sel)
  );

`ifdef FM_STREAM_TAP_TIMESTAMP_EN
  logic [FM_TAG_WIDTH-1:0] ts_q;

  // Free-running timestamp, wraps naturally at all-ones.
  always_ff @(posedge clk_hs) begin
    if (rst_hs) ts_q <= '0;
    else        ts_q <= ts_q + FM_TAG_WIDTH'(1);
  end

  assign tag_now = ts_q;
`else
  assign tag_now = '0;
`endif

  // Next-state, post-window countdown and config-latch strobe.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // through the case leaves one unassigned and infers a latch.
    state_nxt    = state;
    post_cnt_nxt = post_cnt;
    cfg_load     = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ARMED;
          cfg_load  = 1'b1;
        end
        ARMED: begin
          if ((mode_q == WINDOW) && trigger) begin
            if (post_len_q == '0) begin
              state_nxt = DONE;
            end else begin
              state_nxt    = POST;
              post_cnt_nxt = post_len_q;
            end
          end
        end
        POST: begin
          // The trigger-cycle word never lands here, so only post words count.
          if (fwd) begin
            post_cnt_nxt = post_cnt - POST_ONE;
            if (post_cnt == POST_ONE) state_nxt = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Output record: payload and tag hold when nothing is forwarded.
  always_comb begin
    rec_d       = rec_q;
    rec_d.valid = fwd;
    if (fwd) begin
      rec_d.data                 = '0;
      rec_d.data[DATA_WIDTH-1:0] = in_data;
      rec_d.tag                  = tag_now;
    end
  end

  // State, latched configuration and output record registers.
  always_ff @(posedge clk_hs) begin
    if (rst_hs) begin
      state      <= IDLE;
      post_cnt   <= '0;
      mode_q     <= FREE_RUN;
      prescale_q <= '0;
      post_len_q <= '0;
      rec_q      <= '0;
    end else begin
      state    <= state_nxt;
      post_cnt <= post_cnt_nxt;
      rec_q    <= rec_d;
      if (cfg_load) begin
        mode_q     <= tap_mode_t'(mode);
        prescale_q <= prescale;
        post_len_q <= post_len;
      end
    end
  end

  // Saturating count of every trigger seen while enabled.
  always_ff @(posedge clk_hs) begin
    if (rst_hs) begin
      trig_cnt_q <= '0;
    end else if (enable && trigger && (trig_cnt_q != '1)) begin
      trig_cnt_q <= trig_cnt_q + TRIG_ONE;
    end
  end

  assign fm_data    = rec_q.data[DATA_WIDTH-1:0];
  assign fm_valid   = rec_q.valid;
  assign fm_tag     = rec_q.tag;
  assign freeze_req = (state == DONE);
  assign busy       = (state == ARMED) || (state == POST);
  assign trig_count = trig_cnt_q;

endmodule

// File: doc/fm_stream_tap.md
Name: fm_stream_tap

Overview:
- Upstream feeder of the fast-monitoring spy-buffer block.
- Taps one user-logic data stream, applies a prescaler and an optional trigger-window capture, and emits one registered monitor record per selected word.
- On window completion, raises a freeze request that the spy-buffer controller consumes.
- One instance per spy buffer source; outputs form one element of the monitor-data array.

Parameters:
- DATA_WIDTH, 64, width of tapped data word and output record payload.
- PRESCALE_WIDTH, 16, width of prescale setting.
- POST_WIDTH, 10, width of post-trigger word count.
- TRIG_CNT_WIDTH, 8, width of saturating trigger counter.

Ports:
- clk_hs  in  1  single clock for all logic.
- rst_hs  in  1  synchronous, active-high reset.
- enable  in  1  arm tap; 0 forces IDLE.
- mode  in  1  0 = free-run, 1 = trigger-window.
- prescale  in  PRESCALE_WIDTH  forward one of every prescale+1 valid words.
- post_len  in  POST_WIDTH  words forwarded after trigger cycle in window mode.
- in_data  in  DATA_WIDTH  tapped stream data.
- in_valid  in  1  tapped stream qualifier.
- trigger  in  1  single-cycle trigger pulse.
- fm_data  out  DATA_WIDTH  monitor record payload.
- fm_valid  out  1  monitor record valid.
- fm_tag  out  16  record tag (see Optional Feature).
- freeze_req  out  1  level; high in DONE state.
- trig_count  out  TRIG_CNT_WIDTH  triggers accepted plus ignored, saturating.
- busy  out  1  high in ARMED or POST.

Behaviour:
- Reset: all outputs 0, state IDLE, prescaler count 0.
- Latency: in_data/in_valid to fm_data/fm_valid is exactly 1 cycle, registered.
- fm_data holds its last value when fm_valid = 0.
- Config latch: mode, prescale and post_len are latched on the IDLE->ARMED transition; changes while armed are ignored.
- Prescaler:
  - Counts in_valid cycles only.
  - A word is selected when count == 0; count wraps from latched prescale back to 0.
  - prescale = 0 selects every valid word; prescale = 0xFFFF selects 1 of 65536.
- State machine:
  - IDLE: no output. enable=1 -> ARMED.
  - ARMED: selected words forwarded.
    - mode=0: stay in ARMED indefinitely; trigger ignored except counting.
    - mode=1 and trigger -> POST with post counter = latched post_len. If latched post_len = 0, go to DONE instead.
  - POST: selected words forwarded. Each forwarded word decrements the post counter; the word that reaches 0 forwards and the state moves to DONE on the next cycle. Triggers in POST are ignored but counted.
  - DONE: no output, freeze_req=1. Leave only via enable=0 -> IDLE.
- Trigger-cycle word: forwarded if selected; not counted toward post_len.
- enable=0: from any state, IDLE next cycle. In that cycle, fm_valid=0, freeze_req=0 and the prescaler clears.
- Simultaneous: enable falling with a trigger means enable wins (IDLE); the trigger is still counted.
- trig_count:
  - Increments on every trigger while enable=1.
  - Saturates at all-ones.
  - Cleared only by rst_hs.
- Reset mid-capture: immediate return to IDLE on the next edge; no partial freeze_req.
- busy = (state == ARMED or POST).

Optional Feature:
- Macro: FM_STREAM_TAP_TIMESTAMP_EN.
- Defined:
  - A 16-bit free-running counter increments every clk_hs and wraps 0xFFFF->0; it clears on rst_hs.
  - fm_tag carries the counter value sampled in the input cycle of each forwarded word.
- Undefined: fm_tag is tied to 0 and the counter is not built.

Decomposition:
- Package fm_stream_tap_pkg:
  - tap_state_t enum (IDLE, ARMED, POST, DONE).
  - tap_mode_t enum (FREE_RUN, WINDOW).
  - fm_tap_rt struct {data, valid, tag}.
  - Tag width constant 16.
- Sub-module fm_tap_prescaler: counter, wrap and select strobe, with synchronous clear.

Test Plan:
- Free-run, prescale=0, 10 consecutive valid words 0x1..0xA -> 10 fm_valid pulses, each 1 cycle late, data 0x1..0xA.
- Free-run, prescale=3, 16 valid words 0..15 -> forwarded words 0, 4, 8, 12 only.
- Window, prescale=0, post_len=5, trigger on the word 0x20 cycle:
  - 0x20..0x25 forwarded, i.e. trigger word plus 5.
  - DONE entered the cycle after 0x25 is forwarded; freeze_req=1 and no further fm_valid.
- Window, post_len=0, trigger -> DONE next cycle; freeze_req held until enable=0; then IDLE and freeze_req=0 the following cycle.
- Trigger during POST, plus 300 triggers in free-run -> no state change; trig_count saturates at 255.
- rst_hs asserted mid-POST -> all outputs 0 next cycle. With TIMESTAMP_EN, fm_tag restarts from 0 after reset.
